// File: rtl/seg7_pkg.sv
// Shared 7-segment code table and reverse decode helper for the BCD<->7seg path.
// Segment order is {a,b,c,d,e,f,g} with a at bit 6; a 1 means the segment is lit.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG7_CODE [0:9] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
    7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h73
  };

  // Returns {err,bcd}; any pattern outside the table decodes to {1,F}.
  function automatic logic [4:0] seg7_to_bcd(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'h1F;
    for (int i = 0; i < 10; i++)
      if (seg == SEG7_CODE[i]) r = {1'b0, 4'(i)};
    return r;
  endfunction

endpackage

// File: rtl/seg7_pattern_dec.sv
// Combinational 7-segment pattern to BCD decoder with an illegal-code flag.
module seg7_pattern_dec
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_bcd,
  output logic       o_err
);

  logic [4:0] w_dec;

  assign w_dec = seg7_to_bcd(i_seg);
  assign o_err = w_dec[4];
  assign o_bcd = w_dec[3:0];

endmodule

// File: rtl/seg7_scan_decoder.sv
// Debounces a multiplexed 7-seg bus per digit, decodes each digit to BCD and
// emits a complete NDIG-digit frame over a valid/ready port with overrun flag.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg_in,
  input  logic [NDIG-1:0]   dig_en,
  output logic [4*NDIG-1:0] out_bcd,
  output logic [NDIG-1:0]   out_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  input  logic              clr_ovr
);

  localparam int PW = NDIG + 7;
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYC - 1);

  logic [PW-1:0]         w_pair, r_prev;
  logic [CW-1:0]         r_cnt;
  logic                  w_onehot, w_same, w_cap;
  logic [3:0]            w_bcd;
  logic                  w_err;
  logic [NDIG-1:0][3:0]  r_dig;
  logic [NDIG-1:0]       r_derr;
  logic [NDIG-1:0]       r_seen;
  logic                  w_full, w_xfer, w_drop;

  seg7_pattern_dec u_dec (
    .i_seg (seg_in),
    .o_bcd (w_bcd),
    .o_err (w_err)
  );

  assign w_pair   = {dig_en, seg_in};
  assign w_onehot = $onehot(dig_en);
  assign w_same   = (w_pair == r_prev);
  // Fires exactly once per held pair: on the edge the counter passes STABLE_CYC-1.
  assign w_cap    = w_onehot && w_same && (r_cnt == CNT_CAP);

  assign w_full = &r_seen;
  assign w_xfer = w_full && (!out_valid || out_ready);
  assign w_drop = w_full && out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_prev <= w_pair;
      if (!w_onehot)   r_cnt <= '0;
      else if (w_same) r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
      else             r_cnt <= CW'(1);
    end
  end

  generate
    for (genvar g = 0; g < NDIG; g++) begin : g_dig
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dig[g]  <= '0;
          r_derr[g] <= 1'b0;
        end else if (w_cap && dig_en[g]) begin
          r_dig[g]  <= w_bcd;
          r_derr[g] <= w_err;
        end
      end
    end
  endgenerate

  // A full mask is consumed on this edge, but a digit captured now starts the next frame.
  always_ff @(posedge clk) begin
    if (rst) r_seen <= '0;
    else     r_seen <= (w_full ? '0 : r_seen) | (w_cap ? dig_en : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_bcd   <= '0;
      out_err   <= '0;
      out_valid <= 1'b0;
    end else if (w_xfer) begin
      out_bcd   <= r_dig;
      out_err   <= r_derr;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          overrun <= 1'b0;
    else if (w_drop)  overrun <= 1'b1;
    else if (clr_ovr) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed + random bench for seg7_scan_decoder with a run-length reference model.
module tb_seg7_scan_decoder;

  localparam int NDIG = 4;
  localparam int S    = 3;

  logic        clk = 1'b0;
  logic        rst, out_ready, clr_ovr;
  logic [6:0]  seg_in;
  logic [3:0]  dig_en;
  logic [15:0] out_bcd;
  logic [3:0]  out_err;
  logic        out_valid, overrun;

  int errors = 0;
  int checks = 0;

  // reference state
  logic [10:0] m_last;
  int          m_run;
  logic [3:0]  m_dig [4];
  logic [3:0]  m_derr, m_seen, m_err;
  logic [15:0] m_bcd;
  logic        m_valid, m_ovr;

  logic [6:0] codes [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                             7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h73};

  seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_en(dig_en),
    .out_bcd(out_bcd), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_dec(input logic [6:0] s);
    for (int k = 0; k < 10; k++)
      if (s == codes[k]) return {1'b0, 4'(k)};
    return 5'h1F;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [10:0] pair;
    logic [4:0]  d;
    logic [3:0]  nseen;
    logic        full;
    pair = {dig_en, seg_in};
    if (rst) begin
      m_last = '0; m_run = 0; m_derr = '0; m_seen = '0; m_err = '0;
      m_bcd = '0; m_valid = 1'b0; m_ovr = 1'b0;
      for (int k = 0; k < 4; k++) m_dig[k] = '0;
      return;
    end
    m_run  = (pair == m_last) ? m_run + 1 : 1;
    m_last = pair;
    full   = (m_seen == 4'hF);
    if (full && (!m_valid || out_ready)) begin
      for (int k = 0; k < 4; k++) m_bcd[4*k +: 4] = m_dig[k];
      m_err   = m_derr;
      m_valid = 1'b1;
      if (clr_ovr) m_ovr = 1'b0;
    end else if (full) begin
      m_ovr = 1'b1;
    end else begin
      if (m_valid && out_ready) m_valid = 1'b0;
      if (clr_ovr) m_ovr = 1'b0;
    end
    nseen = full ? 4'h0 : m_seen;
    if ($countones(dig_en) == 1 && m_run == S) begin
      d = ref_dec(seg_in);
      for (int k = 0; k < 4; k++)
        if (dig_en[k]) begin
          m_dig[k]  = d[3:0];
          m_derr[k] = d[4];
        end
      nseen = nseen | dig_en;
    end
    m_seen = nseen;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("valid",   {15'd0, out_valid}, {15'd0, m_valid});
    chk("bcd",     out_bcd,            m_bcd);
    chk("err",     {12'd0, out_err},   {12'd0, m_err});
    chk("overrun", {15'd0, overrun},   {15'd0, m_ovr});
  endtask

  task automatic drive(input int idx, input logic [6:0] seg, input int n);
    dig_en = 4'(1 << idx);
    seg_in = seg;
    repeat (n) tick();
  endtask

  task automatic blank(input int n);
    dig_en = 4'h0;
    seg_in = 7'h00;
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; clr_ovr = 1'b0; seg_in = '0; dig_en = '0;
    tick(); tick();
    chk("rst_bcd", out_bcd, 16'h0000);
    chk("rst_valid", {15'd0, out_valid}, 16'h0);
    rst = 1'b0;

    // 1: basic frame, valid one edge after last capture
    out_ready = 1'b1;
    drive(0, 7'h30, 3); drive(1, 7'h6D, 3); drive(2, 7'h79, 3); drive(3, 7'h33, 3);
    chk("t1_pre_valid", {15'd0, out_valid}, 16'h0);
    blank(1);
    chk("t1_valid", {15'd0, out_valid}, 16'h1);
    chk("t1_bcd", out_bcd, 16'h4321);
    chk("t1_err", {12'd0, out_err}, 16'h0);

    // 2: glitch on the last digit must not complete the frame early
    drive(1, 7'h30, 3); drive(2, 7'h6D, 3); drive(3, 7'h79, 3);
    drive(0, 7'h7E, 2);
    chk("t2_no_early", {15'd0, out_valid}, 16'h0);
    drive(0, 7'h5B, 3);
    blank(1);
    chk("t2_bcd", out_bcd, 16'h3215);

    // 3: illegal pattern on digit 2
    drive(0, 7'h7F, 3); drive(1, 7'h73, 3); drive(2, 7'h01, 3); drive(3, 7'h5F, 3);
    blank(1);
    chk("t3_bcd", out_bcd, 16'h6F98);
    chk("t3_err", {12'd0, out_err}, 16'h0004);
    blank(1);

    // 4: stalled consumer, second frame dropped
    out_ready = 1'b0;
    drive(0, 7'h7E, 3); drive(1, 7'h30, 3); drive(2, 7'h6D, 3); drive(3, 7'h79, 3);
    blank(1);
    chk("t4_bcd_a", out_bcd, 16'h3210);
    drive(0, 7'h5B, 3); drive(1, 7'h5F, 3); drive(2, 7'h70, 3); drive(3, 7'h7F, 3);
    blank(2);
    chk("t4_held", out_bcd, 16'h3210);
    chk("t4_ovr", {15'd0, overrun}, 16'h1);
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    chk("t4_clr", {15'd0, overrun}, 16'h0);
    out_ready = 1'b1; tick();
    chk("t4_drop_valid", {15'd0, out_valid}, 16'h0);

    // 5: non-one-hot strobes, then reset mid-frame
    drive(0, 7'h30, 3);
    dig_en = 4'b0011; seg_in = 7'h6D; repeat (4) tick();
    blank(2);
    drive(1, 7'h6D, 3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_rst_bcd", out_bcd, 16'h0000);
    drive(2, 7'h70, 3); drive(3, 7'h5F, 3);
    blank(1);
    chk("t5_partial", {15'd0, out_valid}, 16'h0);
    drive(0, 7'h73, 3); drive(1, 7'h7F, 3);
    blank(1);
    chk("t5_bcd", out_bcd, 16'h6789);
    blank(1);

    // 6: new frame transfers on the same edge the old one is accepted
    out_ready = 1'b0;
    drive(0, 7'h30, 3); drive(1, 7'h6D, 3); drive(2, 7'h79, 3); drive(3, 7'h33, 3);
    blank(1);
    drive(0, 7'h5B, 3); drive(1, 7'h5F, 3); drive(2, 7'h70, 3); drive(3, 7'h7F, 3);
    chk("t6_hold", out_bcd, 16'h4321);
    out_ready = 1'b1; tick();
    chk("t6_valid", {15'd0, out_valid}, 16'h1);
    chk("t6_bcd", out_bcd, 16'h8765);
    chk("t6_ovr", {15'd0, overrun}, 16'h0);

    // random scan traffic
    for (int it = 0; it < 400; it++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      clr_ovr   = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 9))
        0: blank($urandom_range(1, 2));
        1: begin dig_en = 4'($urandom_range(0, 15)); seg_in = 7'($urandom); tick(); end
        2: drive($urandom_range(0, 3), 7'($urandom), $urandom_range(1, 4));
        default: drive($urandom_range(0, 3), codes[$urandom_range(0, 9)], $urandom_range(1, 4));
      endcase
    end
    clr_ovr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
